// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table scanner.
// Holds the scan FSM state encoding, the settle counter width and a
// helper that turns an input count into a truth-table width.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } tts_state_t;

  localparam int TTS_MAX_IN = 4;
  localparam int TTS_CNT_W  = 4;

  // Number of rows in the truth table of an nIn-input function; inputs
  // beyond the supported maximum are clamped.
  function automatic int ttsTableWidth(input int nIn);
    return 1 << ((nIn > TTS_MAX_IN) ? TTS_MAX_IN : nIn);
  endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Settle timer for the truth-table scanner.
// Loadable down-counter: loaded with SETTLE as the FSM enters DRIVE, it
// counts down once per cycle and flags the last cycle a vector must be
// held before the function output may be sampled.
module tts_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);
  import tts_pkg::*;

  localparam logic [TTS_CNT_W-1:0] LOAD_VAL = TTS_CNT_W'(SETTLE);
  localparam logic [TTS_CNT_W-1:0] ONE      = TTS_CNT_W'(1);

  logic [TTS_CNT_W-1:0] count;

  // Reload on DRIVE entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  // The first DRIVE cycle sees SETTLE, so a count of one marks the final one.
  assign expire = (count == ONE);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner top level.
// Walks every input vector of an attached combinational function, holds
// each one for SETTLE cycles, captures the returned Y into table_out and
// finally compares the table against the expected table latched at start.
// Optional build macro TTS_EARLY_ABORT_EN: stop the scan at the first
// captured bit that disagrees with the expected table.
module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      eval_in,
  input  logic                 eval_y,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 match
);
  import tts_pkg::*;

  localparam int T = ttsTableWidth(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

  tts_state_t        state;
  logic [N_IN-1:0]   idx;
  logic [T-1:0]      expLatched;
  logic              lastVec;
  logic              abortNow;
  logic              settleLoad;
  logic              settleExpire;

  assign lastVec = (idx == LAST_IDX);

`ifdef TTS_EARLY_ABORT_EN
  logic yMiss;
  assign yMiss    = (eval_y != expLatched[idx]);
  assign abortNow = yMiss;
`else
  assign abortNow = 1'b0;
`endif

  // The settle timer restarts whenever the FSM is about to enter DRIVE.
  assign settleLoad = ((state == IDLE) && start) ||
                      ((state == SAMPLE) && !lastVec && !abortNow);

  tts_settle_timer #(
    .SETTLE(SETTLE)
  ) uSettleTimer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (settleLoad),
    .expire(settleExpire)
  );

  // Scan sequencer with registered outputs, vector index and table capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      expLatched <= '0;
      eval_in    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      match      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            expLatched <= expected;
            table_out  <= '0;
            match      <= 1'b0;
            idx        <= '0;
            eval_in    <= '0;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          busy <= 1'b1;
          if (settleExpire) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          busy           <= 1'b1;
          table_out[idx] <= eval_y;
          if (lastVec || abortNow) begin
            state <= DONE;
          end else begin
            idx     <= idx + IDX_ONE;
            eval_in <= idx + IDX_ONE;
            state   <= DRIVE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          match <= (table_out == expLatched);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner.
// Two instances: a 3-input scanner with SETTLE=1 driving small boolean
// functions, and a 4-input scanner with SETTLE=3 driving a parity function.
// Expected scan results come from a reference model and travel through a
// scoreboard queue from the start pulse to the done pulse.
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] tbl;
    logic        m;
    int          lat;
  } scanExp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        start3;
  logic [7:0]  exp3;
  logic [2:0]  evalIn3;
  logic        evalY3;
  logic        busy3;
  logic        done3;
  logic [7:0]  table3;
  logic        match3;

  logic        start4;
  logic [15:0] exp4;
  logic [3:0]  evalIn4;
  logic        evalY4;
  logic        busy4;
  logic        done4;
  logic [15:0] table4;
  logic        match4;

  int funcSel3;
  int checkCount = 0;
  int errCount   = 0;

  scanExp_t q3[$];
  scanExp_t q4[$];

  // Reference functions: A is the MSB of the vector, C the LSB.
  function automatic logic refY3(input int sel, input logic [2:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    if (sel == 0) return b | (~a & ~c);
    else          return ~b | c;
  endfunction

  assign evalY3 = refY3(funcSel3, evalIn3);
  assign evalY4 = ^evalIn4;

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) uDut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3),
    .eval_in(evalIn3), .eval_y(evalY3), .busy(busy3), .done(done3),
    .table_out(table3), .match(match3)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(3)) uDut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .expected(exp4),
    .eval_in(evalIn4), .eval_y(evalY4), .busy(busy4), .done(done4),
    .table_out(table4), .match(match4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] want);
    checkCount++;
    if (actual !== want) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, want);
    end
  endtask

  // Expected outcome of one 3-input scan (SETTLE=1, two cycles per vector).
  function automatic scanExp_t model3(input int sel, input logic [7:0] e);
    scanExp_t r;
    logic y;
    r.tbl = '0;
    r.m   = 1'b1;
    r.lat = 8 * 2 + 1;
    for (int i = 0; i < 8; i++) begin
      y = refY3(sel, 3'(i));
      r.tbl[i] = y;
      if (y !== e[i]) begin
        r.m = 1'b0;
`ifdef TTS_EARLY_ABORT_EN
        r.lat = (i + 1) * 2 + 1;
        break;
`endif
      end
    end
    return r;
  endfunction

  // mode 0: plain scan, 1: extra start and expected change mid-scan,
  // 2: reset asserted after ten edges.
  task automatic applyStimulus(input int sel, input logic [7:0] expTbl, input int mode);
    scanExp_t e;
    int edges, busyCycles, doneCnt;
    bit doneSeen, wasReset;
    funcSel3 = sel;
    exp3     = expTbl;
    start3   = 1'b1;
    q3.push_back(model3(sel, expTbl));
    @(posedge clk);
    @(negedge clk);
    start3     = 1'b0;
    edges      = 0;
    busyCycles = 0;
    doneSeen   = 1'b0;
    wasReset   = 1'b0;
    while (!doneSeen && !wasReset && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy3) busyCycles++;
      if (done3) doneSeen = 1'b1;
      if (mode == 1 && edges == 5) begin
        start3 = 1'b1;
        exp3   = ~expTbl;
      end
      if (mode == 1 && edges == 6) start3 = 1'b0;
      if (mode == 2 && edges == 10) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", busy3, 0);
        checkOutput("rstDone", done3, 0);
        checkOutput("rstTable", table3, 0);
        checkOutput("rstMatch", match3, 0);
        checkOutput("rstEvalIn", evalIn3, 0);
        wasReset = 1'b1;
      end
    end
    if (wasReset) begin
      void'(q3.pop_front());
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      doneCnt = 0;
      repeat (40) begin
        @(negedge clk);
        if (done3) doneCnt++;
      end
      checkOutput("noDoneAfterRst", doneCnt, 0);
      checkOutput("idleAfterRst", busy3, 0);
    end else if (!doneSeen) begin
      checkOutput("doneTimeout", doneSeen, 1);
      void'(q3.pop_front());
    end else begin
      e = q3.pop_front();
      checkOutput("latency", edges, e.lat);
      checkOutput("table", table3, e.tbl[7:0]);
      checkOutput("match", match3, e.m);
      checkOutput("busyCycles", busyCycles, e.lat - 1);
      checkOutput("busyAtDone", busy3, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("donePulse", done3, 0);
      checkOutput("tableHeld", table3, e.tbl[7:0]);
      checkOutput("matchHeld", match3, e.m);
      if (mode == 1) begin
        repeat (4) @(negedge clk);
        checkOutput("noQueuedScan", busy3, 0);
      end
    end
  endtask

  // 4-input parity scan with SETTLE=3: each vector is held four cycles.
  task automatic runParity4();
    scanExp_t e;
    int edges, want;
    bit doneSeen;
    e.tbl = '0;
    for (int i = 0; i < 16; i++) e.tbl[i] = ^(4'(i));
    exp4   = 16'h6996;
    e.m    = (e.tbl == exp4);
    e.lat  = 16 * 4 + 1;
    q4.push_back(e);
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4   = 1'b0;
    edges    = 0;
    doneSeen = 1'b0;
    while (!doneSeen && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      want = (edges / 4 > 15) ? 15 : edges / 4;
      checkOutput($sformatf("evalIn4@%0d", edges), evalIn4, want);
      if (done4) doneSeen = 1'b1;
    end
    e = q4.pop_front();
    checkOutput("doneSeen4", doneSeen, 1);
    checkOutput("latency4", edges, e.lat);
    checkOutput("table4", table4, e.tbl);
    checkOutput("match4", match4, e.m);
    repeat (3) @(negedge clk);
    checkOutput("evalInHeld4", evalIn4, 15);
  endtask

  // Start held high: two scans separated by a single IDLE cycle.
  task automatic runBackToBack();
    scanExp_t e;
    int edges, nDone;
    int doneEdge[2];
    doneEdge[0] = 0;
    doneEdge[1] = 0;
    funcSel3 = 0;
    exp3     = 8'hCD;
    start3   = 1'b1;
    q3.push_back(model3(0, 8'hCD));
    q3.push_back(model3(0, 8'hCD));
    @(posedge clk);
    @(negedge clk);
    edges = 0;
    nDone = 0;
    while (nDone < 2 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 18) checkOutput("b2bMatchClr", match3, 0);
      if (done3) begin
        e = q3.pop_front();
        doneEdge[nDone] = edges;
        checkOutput($sformatf("b2bTable%0d", nDone), table3, e.tbl[7:0]);
        checkOutput($sformatf("b2bMatch%0d", nDone), match3, e.m);
        nDone++;
        if (nDone == 2) start3 = 1'b0;
      end
    end
    start3 = 1'b0;
    q3.delete();
    checkOutput("b2bDones", nDone, 2);
    checkOutput("b2bFirst", doneEdge[0], 17);
    checkOutput("b2bSpacing", doneEdge[1] - doneEdge[0], 18);
    repeat (3) @(negedge clk);
    checkOutput("b2bIdle", busy3, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start3   = 1'b0;
    start4   = 1'b0;
    exp3     = '0;
    exp4     = '0;
    funcSel3 = 0;
    repeat (2) @(negedge clk);
    checkOutput("rstVal3Busy", busy3, 0);
    checkOutput("rstVal3Done", done3, 0);
    checkOutput("rstVal3Table", table3, 0);
    checkOutput("rstVal3Match", match3, 0);
    checkOutput("rstVal3EvalIn", evalIn3, 0);
    checkOutput("rstVal4Busy", busy4, 0);
    checkOutput("rstVal4Table", table4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 8'hCD, 0);
    applyStimulus(1, 8'hCD, 0);
    runParity4();
    applyStimulus(0, 8'hCD, 1);
    applyStimulus(0, 8'hCD, 2);
    applyStimulus(0, 8'hCD, 0);
    runBackToBack();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
